toggle_period_meter: RTL and testbench

//  Downstream consumer of the free-running toggle signal (square wave, nominal

---
 rtl/toggle_period_meter.sv | 122 ++++++++++++
 tb/tb_toggle_period_meter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/toggle_period_meter.sv
// Synchronises an async toggling input, emits rise/fall strobes, measures each
// half-period in clk cycles and flags glitches (short half-periods) and stuck input.
module toggle_period_meter #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int MIN_HALF    = 2,
  parameter int TIMEOUT     = 1000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_sig_in,
  output logic             o_rise,
  output logic             o_fall,
  output logic [CNT_W-1:0] o_half_period,
  output logic             o_hp_valid,
  output logic [CNT_W-1:0] o_toggle_cnt,
  output logic             o_glitch,
  output logic             o_stuck
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_STUCK = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] MIN_HALF_C = CNT_W'(MIN_HALF);
  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [CNT_W-1:0]       r_hp_cnt;
  logic [CNT_W-1:0]       w_hp_cnt_nxt;
  logic                   w_sync_last;
  logic                   w_edge;
  logic                   w_measure;
  logic                   w_glitch_nxt;

  assign w_sync_last = r_sync[SYNC_STAGES-1];
  assign w_edge      = w_sync_last ^ r_prev;

  // The synchroniser keeps running while disabled so re-enabling sees a settled level.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig_in};
      r_prev <= w_sync_last;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_hp_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_hp_cnt <= w_hp_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_measure    = 1'b0;
    w_glitch_nxt = 1'b0;
    if (!i_en) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_edge) w_state_nxt = S_ARMED;
        end
        S_ARMED: begin
          if (w_edge) begin
            if (r_hp_cnt >= MIN_HALF_C) w_measure    = 1'b1;
            else                        w_glitch_nxt = 1'b1;
          end else if (r_hp_cnt == TIMEOUT_C) begin
            w_state_nxt = S_STUCK;
          end
        end
        S_STUCK: begin
          if (w_edge) w_state_nxt = S_ARMED;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // The count at an edge is the number of cycles since the previous edge.
  always_comb begin
    w_hp_cnt_nxt = r_hp_cnt;
    if (!i_en)                   w_hp_cnt_nxt = '0;
    else if (w_edge)             w_hp_cnt_nxt = CNT_W'(1);
    else if (r_hp_cnt != CNT_MAX) w_hp_cnt_nxt = r_hp_cnt + CNT_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rise        <= 1'b0;
      o_fall        <= 1'b0;
      o_hp_valid    <= 1'b0;
      o_glitch      <= 1'b0;
      o_half_period <= '0;
      o_toggle_cnt  <= '0;
    end else begin
      o_rise     <= i_en & w_edge & w_sync_last;
      o_fall     <= i_en & w_edge & ~w_sync_last;
      o_hp_valid <= w_measure;
      o_glitch   <= w_glitch_nxt;
      if (w_measure)       o_half_period <= r_hp_cnt;
      if (i_en && w_edge)  o_toggle_cnt  <= o_toggle_cnt + CNT_W'(1);
    end
  end

  assign o_stuck = (r_state == S_STUCK);

endmodule

// File: tb/tb_toggle_period_meter.sv
// Bench for toggle_period_meter: directed vector table, hand-written corner sequences
// and randomised toggling, all compared each cycle against an edge-timestamp model.
module tb_toggle_period_meter;

  localparam int SYNC = 2;
  localparam int CW   = 8;
  localparam int MINH = 2;
  localparam int TMO  = 100;
  localparam int MODV = 1 << CW;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_en = 1'b0;
  logic          i_sig_in = 1'b0;
  logic          o_rise, o_fall, o_hp_valid, o_glitch, o_stuck;
  logic [CW-1:0] o_half_period, o_toggle_cnt;

  toggle_period_meter #(
    .SYNC_STAGES(SYNC), .CNT_W(CW), .MIN_HALF(MINH), .TIMEOUT(TMO)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_sig_in(i_sig_in),
    .o_rise(o_rise), .o_fall(o_fall), .o_half_period(o_half_period),
    .o_hp_valid(o_hp_valid), .o_toggle_cnt(o_toggle_cnt),
    .o_glitch(o_glitch), .o_stuck(o_stuck)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit rst;
    bit en;
    bit sig;
    int n;
    int expTc;
    int expHp;
    bit expStuck;
  } vec_t;

  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  glitchSeen = 0;
  int  strobeSeen = 0;

  // Reference model: edges are timestamped by cycle number; elapsed time is a subtraction.
  bit  sampled [0:SYNC];
  bit  mArmed = 0;
  bit  mStuck = 0;
  int  mLast = 0;
  int  mTc = 0;
  int  mHp = 0;
  bit  eRise = 0, eFall = 0, eHv = 0, eGl = 0;

  task automatic modelStep(input bit rst, input bit en, input bit sig);
    bit lvl, prv, seen;
    int el;
    eRise = 0; eFall = 0; eHv = 0; eGl = 0;
    if (rst) begin
      for (int i = 0; i <= SYNC; i++) sampled[i] = 0;
      mArmed = 0; mStuck = 0; mTc = 0; mHp = 0;
    end else begin
      lvl  = sampled[SYNC-1];
      prv  = sampled[SYNC];
      seen = (lvl != prv);
      if (!en) begin
        mArmed = 0; mStuck = 0;
      end else if (seen) begin
        eRise = lvl; eFall = !lvl;
        mTc = (mTc + 1) % MODV;
        if (mArmed && !mStuck) begin
          el = cyc - mLast;
          if (el >= MINH) begin mHp = el; eHv = 1; end
          else eGl = 1;
        end
        mArmed = 1; mStuck = 0; mLast = cyc;
      end else if (mArmed && !mStuck && (cyc - mLast) == TMO) begin
        mStuck = 1;
      end
      for (int i = SYNC; i > 0; i--) sampled[i] = sampled[i-1];
      sampled[0] = sig;
    end
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic compareCycle();
    logic [20:0] act, exp;
    act = {o_rise, o_fall, o_hp_valid, o_glitch, o_stuck, o_half_period, o_toggle_cnt};
    exp = {eRise, eFall, eHv, eGl, mStuck, CW'(mHp), CW'(mTc)};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL cycle %0d {rise,fall,hv,gl,stuck,hp,tc}: got %b_%b_%b_%b_%b_%0d_%0d, expected %b_%b_%b_%b_%b_%0d_%0d",
               cyc, act[20], act[19], act[18], act[17], act[16], act[15:8], act[7:0],
               exp[20], exp[19], exp[18], exp[17], exp[16], exp[15:8], exp[7:0]);
    end
    if (o_glitch === 1'b1) glitchSeen++;
    if ((o_rise | o_fall | o_hp_valid | o_glitch) === 1'b1) strobeSeen++;
  endtask

  // Holds the given inputs for n cycles, stepping the model and comparing every cycle.
  task automatic applyStimulus(input bit rst, input bit en, input bit sig, input int n);
    for (int c = 0; c < n; c++) begin
      i_rst = rst; i_en = en; i_sig_in = sig;
      @(posedge i_clk);
      cyc++;
      modelStep(rst, en, sig);
      @(negedge i_clk);
      compareCycle();
    end
  endtask

  vec_t vecs [0:15];
  bit   sig;
  bit   en;
  int   r;

  initial begin
    vecs[0]  = '{1, 1, 0, 3,   0, 0, 0};
    vecs[1]  = '{0, 1, 1, 5,   1, 0, 0};
    vecs[2]  = '{0, 1, 0, 5,   2, 5, 0};
    vecs[3]  = '{0, 1, 1, 5,   3, 5, 0};
    vecs[4]  = '{0, 1, 0, 8,   4, 5, 0};
    vecs[5]  = '{0, 1, 1, 8,   5, 8, 0};
    vecs[6]  = '{0, 1, 1, 120, 5, 8, 1};
    vecs[7]  = '{0, 1, 0, 5,   6, 8, 0};
    vecs[8]  = '{0, 1, 1, 5,   7, 5, 0};
    vecs[9]  = '{0, 0, 0, 5,   7, 5, 0};
    vecs[10] = '{0, 0, 1, 5,   7, 5, 0};
    vecs[11] = '{0, 1, 0, 7,   8, 5, 0};
    vecs[12] = '{0, 1, 1, 6,   9, 7, 0};
    vecs[13] = '{1, 1, 1, 3,   0, 0, 0};
    vecs[14] = '{0, 1, 1, 5,   1, 0, 0};
    vecs[15] = '{0, 1, 0, 4,   2, 5, 0};
    for (int i = 0; i <= SYNC; i++) sampled[i] = 0;

    @(negedge i_clk);
    for (int v = 0; v < 16; v++) begin
      applyStimulus(vecs[v].rst, vecs[v].en, vecs[v].sig, vecs[v].n);
      checkOutput($sformatf("vec%0d toggle_cnt", v), int'(o_toggle_cnt), vecs[v].expTc);
      checkOutput($sformatf("vec%0d half_period", v), int'(o_half_period), vecs[v].expHp);
      checkOutput($sformatf("vec%0d stuck", v), int'(o_stuck), int'(vecs[v].expStuck));
    end

    // Two back-to-back one-cycle half-periods right after a legal edge.
    glitchSeen = 0;
    applyStimulus(0, 1, 1, 5);
    applyStimulus(0, 1, 0, 1);
    applyStimulus(0, 1, 1, 1);
    applyStimulus(0, 1, 0, 6);
    checkOutput("glitch pulses", glitchSeen, 2);
    checkOutput("glitch half_period", int'(o_half_period), 5);
    checkOutput("glitch toggle_cnt", int'(o_toggle_cnt), 6);

    // 250 fast edges wrap the 8-bit toggle counter from 6 to 0.
    sig = 0;
    for (int k = 0; k < 250; k++) begin
      sig = !sig;
      applyStimulus(0, 1, sig, 2);
    end
    applyStimulus(0, 1, sig, 3);
    checkOutput("wrap toggle_cnt", int'(o_toggle_cnt), 0);
    checkOutput("wrap half_period", int'(o_half_period), 2);

    // Disabled: edges keep arriving but nothing is reported or counted.
    strobeSeen = 0;
    for (int k = 0; k < 10; k++) begin
      sig = !sig;
      applyStimulus(0, 0, sig, 2);
    end
    applyStimulus(0, 0, sig, 3);
    checkOutput("disabled strobes", strobeSeen, 0);
    checkOutput("disabled toggle_cnt", int'(o_toggle_cnt), 0);
    checkOutput("disabled half_period", int'(o_half_period), 2);

    // Randomised traffic: short/long half-periods, enable drops and occasional resets.
    en = 1;
    for (int seg = 0; seg < 400; seg++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        applyStimulus(1, en, sig, $urandom_range(1, 3));
      end else if (r < 7) begin
        en = !en;
        applyStimulus(0, en, sig, $urandom_range(1, 6));
      end else begin
        sig = !sig;
        applyStimulus(0, en, sig, (r < 11) ? $urandom_range(95, 125) : $urandom_range(1, 9));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
